// File: rtl/hamming_secded_counter_pkg.sv
// Shared Hamming SEC-DED helpers: check-bit sizing, position classification
// and the decoder status encoding.
package hamming_secded_counter_pkg;

   typedef enum logic [1:0] {
      DEC_CLEAN = 2'd0,
      DEC_SEC   = 2'd1,
      DEC_DED   = 2'd2
   } dec_status_e;

   // Smallest P with 2**P >= width + P + 1.
   function automatic int hamming_p(input int width);
      int res;
      res = 0;
      for (int k = 1; k < 16; k++) begin
         if (res == 0 && (1 << k) >= width + k + 1) res = k;
      end
      return res;
   endfunction

   // Codeword positions that are powers of two hold Hamming check bits.
   function automatic logic is_pow2(input int v);
      return (v > 0) && ((v & (v - 1)) == 0);
   endfunction

endpackage

// File: rtl/hamming_secded_counter_dec.sv
// Combinational SEC-DED decoder. Codeword layout: bit 0 is the overall parity,
// bits 1..CW-1 are classic Hamming positions (check bits at powers of two,
// data bits filling the remaining positions in ascending order).
module hamming_secded_dec
   import hamming_secded_counter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int P     = hamming_p(WIDTH),
   parameter int CW    = WIDTH + P + 1
) (
   input  logic [CW-1:0]    code_i,
   output logic [WIDTH-1:0] data_o,
   output dec_status_e      status_o,
   output logic [P-1:0]     syndrome_o
);

   logic [CW-1:0] fixed;
   logic          par;
   int            d;

   // Syndrome/parity evaluation, single-bit correction and data extraction.
   always_comb begin
      syndrome_o = '0;
      for (int pos = 1; pos < CW; pos++) begin
         if (code_i[pos]) syndrome_o = syndrome_o ^ P'(pos);
      end
      par      = ^code_i;
      fixed    = code_i;
      status_o = DEC_CLEAN;
      if (par) begin
         // A syndrome pointing past the last position cannot come from a
         // single flip, so it is reported as uncorrectable.
         if (int'(syndrome_o) > CW - 1) begin
            status_o = DEC_DED;
         end else begin
            status_o = DEC_SEC;
            for (int pos = 0; pos < CW; pos++) begin
               if (P'(pos) == syndrome_o) fixed[pos] = ~fixed[pos];
            end
         end
      end else if (syndrome_o != '0) begin
         status_o = DEC_DED;
      end
      data_o = '0;
      d      = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if (!is_pow2(pos)) begin
            data_o[d] = fixed[pos];
            d++;
         end
      end
   end

endmodule

// File: rtl/hamming_secded_counter.sv
// Free-running counter whose state lives as a SEC-DED codeword. Single-bit
// upsets are corrected on the output and scrubbed on the next edge; double
// upsets freeze the count until a load and are latched in ded_sticky.
module hamming_secded_counter
   import hamming_secded_counter_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 load,
   input  logic [WIDTH-1:0]     load_value,
   input  logic                 clr_err,
   output logic [WIDTH-1:0]     counter,
   output logic                 sec_err,
   output logic                 ded_err,
   output logic                 ded_sticky,
   output logic [ERR_CNT_W-1:0] err_count,
   output logic                 wrap
);

   localparam int P  = hamming_p(WIDTH);
   localparam int CW = WIDTH + P + 1;

   logic [CW-1:0]        code_q, code_d;
   logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic                 ded_sticky_q, ded_sticky_d;
   logic [WIDTH-1:0]     corr;
   dec_status_e          status;
   logic [P-1:0]         syndrome_unused;

   function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] data);
      logic [CW-1:0] cw;
      int            d;
      cw = '0;
      d  = 0;
      for (int pos = 1; pos < CW; pos++) begin
         if (!is_pow2(pos)) begin
            cw[pos] = data[d];
            d++;
         end
      end
      // Check bit at 2**k covers every other position with bit k set.
      for (int k = 0; k < P; k++) begin
         for (int pos = 1; pos < CW; pos++) begin
            if ((((pos >> k) & 1) != 0) && (pos != (1 << k)))
               cw[1 << k] = cw[1 << k] ^ cw[pos];
         end
      end
      cw[0] = ^cw[CW-1:1];
      return cw;
   endfunction

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

   hamming_secded_dec #(
      .WIDTH (WIDTH)
   ) u_dec (
      .code_i     (code_q),
      .data_o     (corr),
      .status_o   (status),
      .syndrome_o (syndrome_unused)
   );

   // Next-state selection: load, DED freeze, increment, else scrub.
   always_comb begin
      code_d = code_q;
      if (load)                   code_d = encode(load_value);
      else if (status == DEC_DED) code_d = code_q;
      else if (enable)            code_d = encode(corr + WIDTH'(1));
      else                        code_d = encode(corr);
      err_cnt_d = err_cnt_q;
      if (clr_err)                err_cnt_d = '0;
      else if (status == DEC_SEC) err_cnt_d = sat_inc(err_cnt_q);
      ded_sticky_d = ded_sticky_q;
      if (status == DEC_DED)      ded_sticky_d = 1'b1;
      else if (clr_err)           ded_sticky_d = 1'b0;
   end

   // State registers with asynchronous reset to the all-zero codeword.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code_q       <= '0;
         err_cnt_q    <= '0;
         ded_sticky_q <= 1'b0;
      end else begin
         code_q       <= code_d;
         err_cnt_q    <= err_cnt_d;
         ded_sticky_q <= ded_sticky_d;
      end
   end

   assign counter    = corr;
   assign sec_err    = (status == DEC_SEC);
   assign ded_err    = (status == DEC_DED);
   assign ded_sticky = ded_sticky_q;
   assign err_count  = err_cnt_q;
   assign wrap       = (&corr) && enable && !load && (status != DEC_DED);

endmodule

// File: tb/tb_hamming_secded_counter.sv
// Directed scoreboard bench for hamming_secded_counter (WIDTH=64, ERR_CNT_W=8).
module tb_hamming_secded_counter;

   localparam int CWT = 72;
   // Hand-derived codeword positions: data bits occupy non-power-of-two
   // positions 3,5,6,7,9,10,11,12,13,... so data7->12, data8->13, data14->20.
   localparam int POS_D7  = 12;
   localparam int POS_D8  = 13;
   localparam int POS_D14 = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [63:0] load_value = '0;
   logic        clr_err = 1'b0;
   logic [63:0] counter;
   logic        sec_err, ded_err, ded_sticky, wrap;
   logic [7:0]  err_count;

   typedef struct {
      string       nm;
      logic [63:0] c;
      bit          s, d, st, w;
      logic [7:0]  cnt;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   hamming_secded_counter #(.WIDTH(64), .ERR_CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .load       (load),
      .load_value (load_value),
      .clr_err    (clr_err),
      .counter    (counter),
      .sec_err    (sec_err),
      .ded_err    (ded_err),
      .ded_sticky (ded_sticky),
      .err_count  (err_count),
      .wrap       (wrap)
   );

   always #5 clk = ~clk;

   function automatic logic [CWT-1:0] bitm(input int p);
      logic [CWT-1:0] m;
      m    = '0;
      m[p] = 1'b1;
      return m;
   endfunction

   function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endfunction

   task automatic cyc(input bit r, input bit en, input bit ld, input logic [63:0] lv,
                      input bit clr, input logic [CWT-1:0] mask, input string nm,
                      input logic [63:0] ec, input bit es, input bit ed, input bit est,
                      input bit ew, input int ecnt);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; enable = en; load = ld; load_value = lv; clr_err = clr;
      if (mask != '0) dut.code_q = dut.code_q ^ mask;
      e.nm = nm; e.c = ec; e.s = es; e.d = ed; e.st = est; e.w = ew; e.cnt = 8'(ecnt);
      exp_q.push_back(e);
   endtask

   // Monitor: compares the oldest expectation against the outputs mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.nm, " counter"},    counter,          e.c);
            chk({e.nm, " sec_err"},    64'(sec_err),     64'(e.s));
            chk({e.nm, " ded_err"},    64'(ded_err),     64'(e.d));
            chk({e.nm, " ded_sticky"}, 64'(ded_sticky),  64'(e.st));
            chk({e.nm, " wrap"},       64'(wrap),        64'(e.w));
            chk({e.nm, " err_count"},  64'(err_count),   64'(e.cnt));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      //            r  en ld lv  clr mask  name       counter s d st w cnt
      cyc(1, 0, 0, 64'd0, 0, '0, "reset", 64'd0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++)
         cyc(0, 1, 0, 64'd0, 0, '0, $sformatf("count%0d", i), 64'(i), 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 64'd0, 0, '0, "hold10", 64'd10, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 64'd0, 0, bitm(POS_D7), "sec_d7", 64'd10, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 64'd0, 0, '0, "scrub_d7", 64'd10, 0, 0, 0, 0, 1);
      // Raw data shown on DED: 10 ^ (1<<8) ^ (1<<14) = 16650.
      cyc(0, 1, 0, 64'd0, 0, bitm(POS_D8) | bitm(POS_D14), "ded", 64'd16650, 0, 1, 0, 0, 1);
      cyc(0, 1, 0, 64'd0, 0, '0, "ded_frozen", 64'd16650, 0, 1, 1, 0, 1);
      cyc(0, 1, 1, 64'd100, 0, '0, "ded_load", 64'd16650, 0, 1, 1, 0, 1);
      cyc(0, 0, 0, 64'd0, 1, '0, "loaded100", 64'd100, 0, 0, 1, 0, 1);
      cyc(0, 0, 0, 64'd0, 0, '0, "cleared", 64'd100, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 64'd0, 0, bitm(0), "sec_par", 64'd100, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 64'd0, 0, '0, "scrub_par", 64'd100, 0, 0, 0, 0, 1);
      cyc(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, '0, "load_ones", 64'd100, 0, 0, 0, 0, 1);
      cyc(0, 1, 0, 64'd0, 0, '0, "wrap", 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 1);
      cyc(0, 0, 0, 64'd0, 0, '0, "wrapped", 64'd0, 0, 0, 0, 0, 1);
      for (int j = 0; j < 260; j++) begin
         cnt = (1 + j > 255) ? 255 : 1 + j;
         cyc(0, 0, 0, 64'd0, 0, bitm(j % CWT), $sformatf("inj%0d", j), 64'd0, 1, 0, 0, 0, cnt);
      end
      cyc(0, 1, 0, 64'd0, 0, '0, "saturated", 64'd0, 0, 0, 0, 0, 255);
      cyc(0, 1, 0, 64'd0, 0, '0, "post_sat", 64'd1, 0, 0, 0, 0, 255);
      cyc(1, 1, 0, 64'd0, 0, '0, "mid_reset", 64'd0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 64'd0, 0, '0, "after_reset", 64'd0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
      @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
